int_to_fp_arbiter: RTL

- Shares one int_to_fp converter instance between NUM_REQ requesters, e.g. per-band accumulators in the LCMV datapath.
- Grants one requester per cycle using round-robin arbitration and issues its integer to the converter.
- Records the owner of each in-flight conversion in an order-preserving tag FIFO.
- Routes each converter result back to its owner with a one-hot valid.

---
 rtl/int_to_fp_arb_pkg.sv | 30 +++
 rtl/int_to_fp_arbiter_tag_fifo.sv | 53 +++++
 rtl/int_to_fp_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/int_to_fp_arb_pkg.sv
// Shared types and the round-robin search used by the int_to_fp arbiter.
// Tags are sized for the largest supported requester count.
package int_to_fp_arb_pkg;

  localparam int NUM_REQ_MAX = 16;
  localparam int TAG_W       = $clog2(NUM_REQ_MAX);

  typedef logic [TAG_W-1:0] tag_t;

  // Returns {found, index}: first set bit of req at or above ptr, wrapping at num_req.
  function automatic logic [TAG_W:0] rr_pick(input logic [NUM_REQ_MAX-1:0] req,
                                              input tag_t ptr,
                                              input int num_req);
    logic found;
    tag_t idx;
    int   cand;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ_MAX; i++) begin
      cand = int'(ptr) + i;
      if (cand >= num_req) cand = cand - num_req;
      if (i < num_req && !found && req[cand[TAG_W-1:0]]) begin
        found = 1'b1;
        idx   = cand[TAG_W-1:0];
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/int_to_fp_arbiter_tag_fifo.sv
// Order-preserving FIFO of owner tags for in-flight conversions.
// Read is combinational so the owner is known in the same cycle as conv_valid.
module tag_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             push_ok, pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr_reg];
  assign count    = count_reg;
  assign full     = (count_reg == (PTR_W+1)'(DEPTH));
  assign empty    = (count_reg == '0);

endmodule

// File: rtl/int_to_fp_arbiter.sv
// Round-robin share of one int_to_fp converter among NUM_REQ requesters,
// returning each result to its owner via a one-hot valid.
module int_to_fp_arbiter
  import int_to_fp_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int INT_WIDTH    = 32,
  parameter int FP_WIDTH     = 32,
  parameter int MAX_INFLIGHT = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ*INT_WIDTH-1:0] req_in,
  input  logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           req_ack,
  output logic [INT_WIDTH-1:0]         conv_in,
  output logic                         conv_ready,
  input  logic [FP_WIDTH-1:0]          conv_out,
  input  logic                         conv_valid,
  output logic [FP_WIDTH-1:0]          rsp_out,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic                         busy,
  output logic                         err_overflow
);

  localparam int CNT_W = $clog2(MAX_INFLIGHT) + 1;

  logic [NUM_REQ_MAX-1:0] req_pad;
  logic [TAG_W:0]         pick;
  logic                   grant, pop;
  tag_t                   grant_idx, rr_ptr_reg, rr_ptr_next, pop_tag;
  logic [INT_WIDTH-1:0]   grant_data, conv_in_reg;
  logic                   conv_ready_reg, err_overflow_reg;
  logic [FP_WIDTH-1:0]    rsp_out_reg;
  logic [NUM_REQ-1:0]     rsp_valid_reg;
  logic [CNT_W-1:0]       fifo_count;
  logic                   fifo_full, fifo_empty;

  for (genvar gi = 0; gi < NUM_REQ_MAX; gi++) begin : g_pad
    if (gi < NUM_REQ) begin : g_used
      assign req_pad[gi] = req_ready[gi];
    end else begin : g_unused
      assign req_pad[gi] = 1'b0;
    end
  end

  // A full FIFO blocks grants even if a pop happens this cycle.
  assign pick      = rr_pick(req_pad, rr_ptr_reg, NUM_REQ);
  assign grant     = !rst && !fifo_full && pick[TAG_W];
  assign grant_idx = pick[TAG_W-1:0];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ack
    assign req_ack[gi] = grant && (grant_idx == tag_t'(gi));
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == tag_t'(i)) grant_data = req_in[i*INT_WIDTH +: INT_WIDTH];
    end
  end

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (grant) rr_ptr_next = (grant_idx == tag_t'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
  end

  assign pop = conv_valid && !fifo_empty;

  tag_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (MAX_INFLIGHT)
  ) u_tag_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (grant),
    .push_data (grant_idx),
    .pop       (pop),
    .pop_data  (pop_tag),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_reg       <= '0;
      conv_in_reg      <= '0;
      conv_ready_reg   <= 1'b0;
      rsp_out_reg      <= '0;
      rsp_valid_reg    <= '0;
      err_overflow_reg <= 1'b0;
    end else begin
      rr_ptr_reg     <= rr_ptr_next;
      conv_ready_reg <= grant;
      if (grant) conv_in_reg <= grant_data;
      rsp_valid_reg  <= pop ? (NUM_REQ'(1) << pop_tag) : '0;
      if (pop) rsp_out_reg <= conv_out;
      // A result with no recorded owner can only mean lost bookkeeping.
      if (conv_valid && fifo_empty) err_overflow_reg <= 1'b1;
    end
  end

  assign conv_in      = conv_in_reg;
  assign conv_ready   = conv_ready_reg;
  assign rsp_out      = rsp_out_reg;
  assign rsp_valid    = rsp_valid_reg;
  assign err_overflow = err_overflow_reg;
  assign busy         = (fifo_count != '0);

endmodule
